// File: rtl/reg_view_ctrl.sv
// Front-panel sequencer for the register-view mux: debounced buttons or an
// auto dwell timer step sel/half, and the selected half is driven on led.
module reg_view_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_REGS     = 10,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned DB_CYCLES    = 1000000,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             btn_half,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] reg_data,
  output logic [3:0]       sel,
  output logic             half,
  output logic [LED_W-1:0] led,
  output logic             idx_change
);

  localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned NB   = 3;
  localparam int unsigned NS   = 4;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } state_t;

  // Bit order of synchronizer vectors: {auto_en, btn_half, btn_prev, btn_next}
  logic [NS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]   db_q, db_d, ev_q, ev_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];
  logic [DW_W-1:0] dwell_q, dwell_d;
  state_t          state_q, state_d;
  logic [3:0]      sel_q, sel_d, sel_inc, sel_dec;
  logic [LED_W-1:0] led_q, led_d;
  logic            idx_q, idx_d;
  logic            auto_s, mv_next, mv_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      ev_q    <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      dwell_q <= '0;
      state_q <= S_LO;
      sel_q   <= '0;
      led_q   <= '0;
      idx_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      ev_q    <= ev_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      dwell_q <= dwell_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      idx_q   <= idx_d;
    end
  end

  // Two-flop synchronizers and per-button debounce with registered press pulse
  always_comb begin
    sync1_d = {auto_en, btn_half, btn_prev, btn_next};
    sync2_d = sync1_q;
    for (int i = 0; i < NB; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      ev_d[i]     = 1'b0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
          ev_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign auto_s  = sync2_q[3];
  assign mv_next = ev_q[0] & ~ev_q[1];
  assign mv_prev = ev_q[1] & ~ev_q[0];
  assign sel_inc = (sel_q == 4'(NUM_REGS - 1)) ? 4'd0 : sel_q + 4'd1;
  assign sel_dec = (sel_q == 4'd0) ? 4'(NUM_REGS - 1) : sel_q - 4'd1;

  // Mode FSM: state is the displayed half; auto mode walks LO->HI->next LO
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = '0;
    if (auto_s) begin
      if (dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
        unique case (state_q)
          S_LO: state_d = S_HI;
          S_HI: begin
            state_d = S_LO;
            sel_d   = sel_inc;
          end
          default: state_d = S_LO;
        endcase
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end else if (mv_next) begin
      sel_d   = sel_inc;
      state_d = S_LO;
    end else if (mv_prev) begin
      sel_d   = sel_dec;
      state_d = S_LO;
    end else if (ev_q[2]) begin
      state_d = (state_q == S_LO) ? S_HI : S_LO;
    end
    idx_d = (sel_d != sel_q);
    led_d = (state_q == S_HI) ? reg_data[WIDTH-1:LED_W] : reg_data[LED_W-1:0];
  end

  assign sel        = sel_q;
  assign half       = (state_q == S_HI);
  assign led        = led_q;
  assign idx_change = idx_q;

endmodule

// File: tb/tb_reg_view_ctrl.sv
// Self-checking bench for reg_view_ctrl: directed scenarios plus random
// button/switch activity compared every cycle against a behavioural model.
module tb_reg_view_ctrl;

  localparam int DB = 4;
  localparam int DW = 8;
  localparam int NR = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_next, btn_prev, btn_half, auto_en;
  logic [31:0] reg_data;
  logic [3:0]  sel;
  logic        half;
  logic [15:0] led;
  logic        idx_change;

  logic [31:0] regs [16];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: input pipeline, accepted levels, run lengths, press flags
  int m_s1 [4];
  int m_s2 [4];
  int m_lvl [3];
  int m_run [3];
  int m_ev [3];
  int m_sel, m_half, m_led, m_idx, m_dwell;

  reg_view_ctrl #(
    .WIDTH(32), .NUM_REGS(NR), .LED_W(16), .DB_CYCLES(DB), .DWELL_CYCLES(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_half(btn_half), .auto_en(auto_en), .reg_data(reg_data),
    .sel(sel), .half(half), .led(led), .idx_change(idx_change)
  );

  always #5 clk = ~clk;

  assign reg_data = regs[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0;
      m_s2[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 0;
      m_run[i] = 0;
      m_ev[i]  = 0;
    end
    m_sel = 0; m_half = 0; m_led = 0; m_idx = 0; m_dwell = 0;
  endtask

  task automatic model_step();
    int raw [4];
    int old_sel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw[0] = int'(btn_next); raw[1] = int'(btn_prev);
    raw[2] = int'(btn_half); raw[3] = int'(auto_en);
    old_sel = m_sel;
    m_led = m_half ? int'(regs[m_sel][31:16]) : int'(regs[m_sel][15:0]);
    if (m_s2[3] == 1) begin
      // each half shown for DW cycles; after high half move to next register
      if (m_dwell == DW - 1) begin
        m_dwell = 0;
        if (m_half == 1) begin
          m_half = 0;
          m_sel = (m_sel + 1) % NR;
        end else begin
          m_half = 1;
        end
      end else begin
        m_dwell++;
      end
    end else begin
      m_dwell = 0;
      if (m_ev[0] == 1 && m_ev[1] == 0) begin
        m_sel = (m_sel + 1) % NR; m_half = 0;
      end else if (m_ev[1] == 1 && m_ev[0] == 0) begin
        m_sel = (m_sel + NR - 1) % NR; m_half = 0;
      end else if (m_ev[2] == 1) begin
        m_half = 1 - m_half;
      end
    end
    m_idx = (m_sel != old_sel) ? 1 : 0;
    // a new level is accepted on its DB-th consecutive differing sample
    for (int i = 0; i < 3; i++) begin
      m_ev[i] = 0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
          m_ev[i]  = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("sel", 32'(sel), 32'(m_sel));
    check("half", 32'(half), 32'(m_half));
    check("led", 32'(led), 32'(m_led));
    check("idx_change", 32'(idx_change), 32'(m_idx));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_next = v;
      1: btn_prev = v;
      default: btn_half = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    ticks(10);
    set_btn(b, 1'b0);
    ticks(10);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_half"}, 32'(half), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_idx"}, 32'(idx_change), 32'd0);
  endtask

  // Cycles from stimulus until sel first moves; -1 if it never does
  task automatic measure_step(input int limit, output int lat);
    logic [3:0] start;
    start = sel;
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (lat < 0 && sel != start) lat = k;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_half = 1'b0; auto_en = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    model_reset();
    #3;
    check_zero("reset");
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // clean press: pulse at DB+2 after edge, sel registered one cycle later
    btn_next = 1'b1;
    measure_step(20, lat);
    check("next_latency", 32'(lat), 32'(DB + 3));
    check("held_once", 32'(sel), 32'd1);
    btn_next = 1'b0;
    ticks(10);

    // bouncing input only steps once it has settled
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      ticks(2);
    end
    check("bounce_nostep", 32'(sel), 32'd1);
    btn_next = 1'b1;
    ticks(12);
    check("bounce_step", 32'(sel), 32'd2);
    btn_next = 1'b0;
    ticks(10);

    for (int i = 0; i < 7; i++) press(0);
    check("to_nine", 32'(sel), 32'd9);
    press(0);
    check("wrap_up", 32'(sel), 32'd0);
    press(1);
    check("wrap_down", 32'(sel), 32'd9);
    for (int i = 0; i < 4; i++) press(1);
    check("at_five", 32'(sel), 32'd5);
    btn_next = 1'b1; btn_prev = 1'b1;
    ticks(10);
    btn_next = 1'b0; btn_prev = 1'b0;
    ticks(10);
    check("both_ignored", 32'(sel), 32'd5);

    regs[3] = 32'hDEAD_BEEF;
    regs[4] = 32'h1234_5678;
    press(1);
    press(1);
    check("at_three", 32'(sel), 32'd3);
    press(2);
    check("half_hi", 32'(half), 32'd1);
    check("led_hi", 32'(led), 32'h0000_DEAD);
    press(0);
    check("next_clears_half", 32'(half), 32'd0);
    check("next_sel", 32'(sel), 32'd4);
    check("led_lo", 32'(led), 32'h0000_5678);

    for (int i = 0; i < 4; i++) press(0);
    check("at_eight", 32'(sel), 32'd8);
    auto_en = 1'b1;
    ticks(10);
    check("auto_hi_sel", 32'(sel), 32'd8);
    check("auto_hi", 32'(half), 32'd1);
    btn_next = 1'b1;
    ticks(8);
    check("auto_nine", 32'(sel), 32'd9);
    check("auto_nine_lo", 32'(half), 32'd0);
    btn_next = 1'b0;
    btn_half = 1'b1;
    ticks(16);
    check("auto_wrap", 32'(sel), 32'd0);
    btn_half = 1'b0;
    ticks(3);

    // reset mid-scan with a button being debounced and held through release
    btn_next = 1'b1;
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    auto_en = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    measure_step(20, lat);
    check("held_rst_latency", 32'(lat), 32'(DB + 3));
    check("held_rst_sel", 32'(sel), 32'd1);
    btn_next = 1'b0;
    ticks(10);

    // random activity against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(7, 0) == 0) btn_next = ~btn_next;
      if ($urandom_range(7, 0) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(7, 0) == 0) btn_half = ~btn_half;
      if ($urandom_range(149, 0) == 0) auto_en = ~auto_en;
      if ($urandom_range(9, 0) == 0) regs[$urandom_range(15, 0)] = $urandom;
      rst_n = ($urandom_range(599, 0) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
